// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: classifies fetched instructions, holds the ID pipeline
// register for EX, and owns stall, flush and load-use bubble insertion.
module id_stage_ctrl #(
   parameter int N     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_valid,
   input  logic [N-1:0]     if_instr,
   input  logic [N-1:0]     if_pc,
   output logic             if_ready,
   input  logic             ex_ready,
   input  logic             flush,
   output logic             id_valid,
   output logic [N-1:0]     id_instr,
   output logic [N-1:0]     id_pc,
   output logic [1:0]       id_imm_sel,
   output logic [4:0]       id_rs1,
   output logic [4:0]       id_rs2,
   output logic [4:0]       id_rd,
   output logic             id_is_load,
   output logic             id_is_jal,
   output logic             id_illegal,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [1:0]       dbg_state
);

   // Handshake: an instruction moves IF->ID on a rising edge where if_valid and
   // if_ready are both high; the ID entry retires to EX on an edge with id_valid
   // and ex_ready high. if_ready never depends on if_valid.

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_FULL   = 2'd1,
      ST_STALL  = 2'd2,
      ST_BUBBLE = 2'd3
   } state_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   state_e           state_q, state_d;
   logic             id_valid_q, id_valid_d;
   logic [N-1:0]     id_instr_q, id_instr_d;
   logic [N-1:0]     id_pc_q, id_pc_d;
   logic [1:0]       id_imm_sel_q, id_imm_sel_d;
   logic [4:0]       id_rs1_q, id_rs1_d;
   logic [4:0]       id_rs2_q, id_rs2_d;
   logic [4:0]       id_rd_q, id_rd_d;
   logic             id_is_load_q, id_is_load_d;
   logic             id_is_jal_q, id_is_jal_d;
   logic             id_illegal_q, id_illegal_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   logic [6:0] opcode;
   logic [1:0] dec_imm_sel;
   logic [4:0] dec_rd;
   logic       dec_load, dec_jal, dec_illegal;
   logic       uses_rs1, uses_rs2;
   logic       hazard, accept;

   assign opcode = if_instr[6:0];

   always_comb begin
      dec_imm_sel = 2'd0;
      dec_rd      = if_instr[11:7];
      dec_load    = 1'b0;
      dec_jal     = 1'b0;
      dec_illegal = 1'b0;
      uses_rs1    = 1'b1;
      uses_rs2    = 1'b0;
      unique case (opcode)
         OPC_LOAD:             dec_load = 1'b1;
         OPC_OP_IMM, OPC_JALR: ;
         // CSR immediate forms (funct3[2]=1) carry a zimm in the rs1 field
         OPC_SYSTEM:           uses_rs1 = ~if_instr[14];
         OPC_STORE: begin
            dec_imm_sel = 2'd1;
            dec_rd      = 5'd0;
            uses_rs2    = 1'b1;
         end
         OPC_BRANCH: begin
            dec_imm_sel = 2'd2;
            dec_rd      = 5'd0;
            uses_rs2    = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            dec_imm_sel = 2'd3;
            uses_rs1    = 1'b0;
         end
         OPC_JAL: begin
            dec_jal  = 1'b1;
            uses_rs1 = 1'b0;
         end
         OPC_OP:               uses_rs2 = 1'b1;
         default:              dec_illegal = 1'b1;
      endcase
   end

   assign hazard = id_valid_q & id_is_load_q & (id_rd_q != 5'd0) &
                   ((uses_rs1 & (if_instr[19:15] == id_rd_q)) |
                    (uses_rs2 & (if_instr[24:20] == id_rd_q)));

   assign if_ready = rst_n & ~flush & ~hazard & (~id_valid_q | ex_ready);
   assign accept   = if_valid & if_ready;

   always_comb begin
      state_d      = state_q;
      id_valid_d   = id_valid_q;
      id_instr_d   = id_instr_q;
      id_pc_d      = id_pc_q;
      id_imm_sel_d = id_imm_sel_q;
      id_rs1_d     = id_rs1_q;
      id_rs2_d     = id_rs2_q;
      id_rd_d      = id_rd_q;
      id_is_load_d = id_is_load_q;
      id_is_jal_d  = id_is_jal_q;
      id_illegal_d = id_illegal_q;
      bubble_cnt_d = bubble_cnt_q;
      if (flush) begin
         // Fields are left untouched; only the valid bit is killed
         id_valid_d = 1'b0;
         state_d    = ST_EMPTY;
      end else if (accept) begin
         id_valid_d   = 1'b1;
         id_instr_d   = if_instr;
         id_pc_d      = if_pc;
         id_imm_sel_d = dec_imm_sel;
         id_rs1_d     = if_instr[19:15];
         id_rs2_d     = if_instr[24:20];
         id_rd_d      = dec_rd;
         id_is_load_d = dec_load;
         id_is_jal_d  = dec_jal;
         id_illegal_d = dec_illegal;
         state_d      = ST_FULL;
      end else if (hazard & id_valid_q & ex_ready) begin
         id_valid_d   = 1'b0;
         bubble_cnt_d = (&bubble_cnt_q) ? bubble_cnt_q : bubble_cnt_q + CNT_W'(1);
         state_d      = ST_BUBBLE;
      end else if (id_valid_q & ex_ready) begin
         id_valid_d = 1'b0;
         state_d    = ST_EMPTY;
      end else if (id_valid_q) begin
         state_d = ST_STALL;
      end else begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_EMPTY;
         id_valid_q   <= 1'b0;
         id_instr_q   <= '0;
         id_pc_q      <= '0;
         id_imm_sel_q <= 2'd0;
         id_rs1_q     <= 5'd0;
         id_rs2_q     <= 5'd0;
         id_rd_q      <= 5'd0;
         id_is_load_q <= 1'b0;
         id_is_jal_q  <= 1'b0;
         id_illegal_q <= 1'b0;
         bubble_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         id_valid_q   <= id_valid_d;
         id_instr_q   <= id_instr_d;
         id_pc_q      <= id_pc_d;
         id_imm_sel_q <= id_imm_sel_d;
         id_rs1_q     <= id_rs1_d;
         id_rs2_q     <= id_rs2_d;
         id_rd_q      <= id_rd_d;
         id_is_load_q <= id_is_load_d;
         id_is_jal_q  <= id_is_jal_d;
         id_illegal_q <= id_illegal_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign id_valid   = id_valid_q;
   assign id_instr   = id_instr_q;
   assign id_pc      = id_pc_q;
   assign id_imm_sel = id_imm_sel_q;
   assign id_rs1     = id_rs1_q;
   assign id_rs2     = id_rs2_q;
   assign id_rd      = id_rd_q;
   assign id_is_load = id_is_load_q;
   assign id_is_jal  = id_is_jal_q;
   assign id_illegal = id_illegal_q;
   assign bubble_cnt = bubble_cnt_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Bench for id_stage_ctrl: decode table streamed through the handshake, a reference
// scoreboard on the EX side, and hand sequences for stall, hazard, flush and reset.
module tb_id_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, if_valid, ex_ready, flush;
   logic [31:0] if_instr, if_pc;

   logic        if_ready, id_valid, id_is_load, id_is_jal, id_illegal;
   logic [31:0] id_instr, id_pc;
   logic [1:0]  id_imm_sel, dbg_state;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [15:0] bubble_cnt;

   logic        s_if_ready, s_id_valid, s_id_is_load, s_id_is_jal, s_id_illegal;
   logic [31:0] s_id_instr, s_id_pc;
   logic [1:0]  s_id_imm_sel, s_dbg_state;
   logic [4:0]  s_id_rs1, s_id_rs2, s_id_rd;
   logic [1:0]  s_bubble_cnt;

   id_stage_ctrl #(.N(32), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .if_ready(if_ready), .ex_ready(ex_ready), .flush(flush), .id_valid(id_valid),
      .id_instr(id_instr), .id_pc(id_pc), .id_imm_sel(id_imm_sel), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_rd(id_rd), .id_is_load(id_is_load), .id_is_jal(id_is_jal),
      .id_illegal(id_illegal), .bubble_cnt(bubble_cnt), .dbg_state(dbg_state)
   );

   id_stage_ctrl #(.N(32), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .if_ready(s_if_ready), .ex_ready(ex_ready), .flush(flush), .id_valid(s_id_valid),
      .id_instr(s_id_instr), .id_pc(s_id_pc), .id_imm_sel(s_id_imm_sel), .id_rs1(s_id_rs1),
      .id_rs2(s_id_rs2), .id_rd(s_id_rd), .id_is_load(s_id_is_load), .id_is_jal(s_id_is_jal),
      .id_illegal(s_id_illegal), .bubble_cnt(s_bubble_cnt), .dbg_state(s_dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [1:0]  sel;
      logic [4:0]  rd;
      logic        ld;
      logic        jal;
      logic        ill;
   } vec_t;

   vec_t        tbl[14];
   int          ord[17] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 9, 12, 9, 13, 9, 11};
   logic [83:0] exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          last_wait;
   bit          mon_en = 1'b0;
   vec_t        cur;
   logic [31:0] cur_pc;

   // Reference state of the ID register as seen from the fetch side
   logic        m_valid = 1'b0;
   logic        m_ld = 1'b0;
   logic [4:0]  m_rd = 5'd0;
   int          m_cnt = 0;
   logic        m_haz, m_ready;
   logic [83:0] e_pop;

   function automatic logic [83:0] pack_exp(vec_t v, logic [31:0] pc);
      return {pc, v.instr, v.sel, v.instr[19:15], v.instr[24:20], v.rd, v.ld, v.jal, v.ill};
   endfunction

   function automatic logic [83:0] pack_act();
      return {id_pc, id_instr, id_imm_sel, id_rs1, id_rs2, id_rd, id_is_load, id_is_jal, id_illegal};
   endfunction

   function automatic bit f_u1(logic [31:0] i);
      case (i[6:0])
         7'b0110111, 7'b0010111, 7'b1101111: return 1'b0;
         7'b1110011:                         return !i[14];
         default:                            return 1'b1;
      endcase
   endfunction

   function automatic bit f_u2(logic [31:0] i);
      case (i[6:0])
         7'b1100011, 7'b0100011, 7'b0110011: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic present(int idx, logic [31:0] pc);
      cur      = tbl[idx];
      cur_pc   = pc;
      if_valid = 1'b1;
      if_instr = tbl[idx].instr;
      if_pc    = pc;
   endtask

   task automatic idle();
      if_valid = 1'b0;
      if_instr = 32'h0;
      if_pc    = 32'h0;
   endtask

   // Presents one instruction, waits (bounded) for acceptance, checks the ID fields
   task automatic send(int idx, logic [31:0] pc);
      bit acc;
      int n;
      present(idx, pc);
      n = 0;
      acc = 1'b0;
      do begin
         @(negedge clk);
         acc = if_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 20);
      last_wait = n;
      chk("send_accept", 128'(acc), 128'(1));
      idle();
      chk("id_valid_after_accept", 128'(id_valid), 128'(1));
      chk("id_fields", 128'(pack_act()), 128'(pack_exp(tbl[idx], pc)));
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         m_haz = m_valid && m_ld && (m_rd != 5'd0) &&
                 ((f_u1(if_instr) && if_instr[19:15] == m_rd) ||
                  (f_u2(if_instr) && if_instr[24:20] == m_rd));
         m_ready = rst_n && !flush && !m_haz && (!m_valid || ex_ready);
         chk("if_ready", 128'(if_ready), 128'(m_ready));
         chk("sat_if_ready", 128'(s_if_ready), 128'(m_ready));
         chk("id_valid", 128'(id_valid), 128'(m_valid));
         chk("bubble_cnt", 128'(bubble_cnt), 128'(m_cnt));
         chk("bubble_cnt_sat", 128'(s_bubble_cnt), 128'((m_cnt > 3) ? 3 : m_cnt));
         if (m_valid && (!rst_n || flush)) begin
            if (exp_q.size() > 0) e_pop = exp_q.pop_front();
         end else if (m_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
               chk("ex_out_unexpected", 128'(1), 128'(0));
            end else begin
               e_pop = exp_q.pop_front();
               chk("ex_out", 128'(pack_act()), 128'(e_pop));
            end
         end
         if (!rst_n) begin
            m_valid = 1'b0;
            m_ld    = 1'b0;
            m_rd    = 5'd0;
            m_cnt   = 0;
         end else if (flush) begin
            m_valid = 1'b0;
         end else if (if_valid && m_ready) begin
            m_valid = 1'b1;
            m_ld    = cur.ld;
            m_rd    = cur.rd;
            exp_q.push_back(pack_exp(cur, cur_pc));
         end else if (m_haz && ex_ready) begin
            m_valid = 1'b0;
            m_cnt++;
         end else if (m_valid && ex_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   initial begin
      tbl[0]  = '{32'h00500093, 2'd0, 5'd1, 1'b0, 1'b0, 1'b0};  // ADDI x1,x0,5
      tbl[1]  = '{32'h00112223, 2'd1, 5'd0, 1'b0, 1'b0, 1'b0};  // SW x1,4(x2)
      tbl[2]  = '{32'h00208463, 2'd2, 5'd0, 1'b0, 1'b0, 1'b0};  // BEQ x1,x2
      tbl[3]  = '{32'h123450B7, 2'd3, 5'd1, 1'b0, 1'b0, 1'b0};  // LUI x1
      tbl[4]  = '{32'h0000007F, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1};  // illegal
      tbl[5]  = '{32'h008000EF, 2'd0, 5'd1, 1'b0, 1'b1, 1'b0};  // JAL x1
      tbl[6]  = '{32'h00001197, 2'd3, 5'd3, 1'b0, 1'b0, 1'b0};  // AUIPC x3
      tbl[7]  = '{32'h000280E7, 2'd0, 5'd1, 1'b0, 1'b0, 1'b0};  // JALR x1,0(x5)
      tbl[8]  = '{32'h00000073, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0};  // ECALL
      tbl[9]  = '{32'h0000A283, 2'd0, 5'd5, 1'b1, 1'b0, 1'b0};  // LW x5,0(x1)
      tbl[10] = '{32'h00728333, 2'd0, 5'd6, 1'b0, 1'b0, 1'b0};  // ADD x6,x5,x7
      tbl[11] = '{32'h00700333, 2'd0, 5'd6, 1'b0, 1'b0, 1'b0};  // ADD x6,x0,x7
      tbl[12] = '{32'h00512023, 2'd1, 5'd0, 1'b0, 1'b0, 1'b0};  // SW x5,0(x2)
      tbl[13] = '{32'h000283B7, 2'd3, 5'd7, 1'b0, 1'b0, 1'b0};  // LUI x7, rs1 field = 5

      rst_n    = 1'b0;
      ex_ready = 1'b0;
      flush    = 1'b0;
      idle();
      cur    = tbl[0];
      cur_pc = 32'h0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_fields", 128'(pack_act()), 128'(0));
      chk("reset_valid", 128'(id_valid), 128'(0));
      chk("reset_cnt", 128'(bubble_cnt), 128'(0));
      chk("reset_state", 128'(dbg_state), 128'(0));
      rst_n = 1'b1;

      // Three-cycle EX stall: ID contents frozen, fetch blocked
      ex_ready = 1'b1;
      send(0, 32'h100);
      ex_ready = 1'b0;
      present(1, 32'h104);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("stall_if_ready", 128'(if_ready), 128'(0));
         @(posedge clk);
         #1;
         chk("stall_instr", 128'(id_instr), 128'(tbl[0].instr));
         chk("stall_pc", 128'(id_pc), 128'(32'h100));
         chk("stall_sel", 128'(id_imm_sel), 128'(0));
      end
      chk("stall_state", 128'(dbg_state), 128'(2));
      ex_ready = 1'b1;
      send(1, 32'h104);

      // Load-use hazard through rs1
      send(9, 32'h200);
      present(10, 32'h204);
      @(negedge clk);
      chk("haz_if_ready", 128'(if_ready), 128'(0));
      @(posedge clk);
      #1;
      chk("haz_bubble_valid", 128'(id_valid), 128'(0));
      chk("haz_cnt", 128'(bubble_cnt), 128'(1));
      chk("haz_state", 128'(dbg_state), 128'(3));
      @(negedge clk);
      chk("haz_ready_after", 128'(if_ready), 128'(1));
      @(posedge clk);
      #1;
      chk("haz_dep_in_id", 128'(id_instr), 128'(tbl[10].instr));
      chk("haz_dep_valid", 128'(id_valid), 128'(1));
      idle();

      // Same load, independent consumer: no bubble
      send(9, 32'h300);
      send(11, 32'h304);
      chk("nohaz_wait", 128'(last_wait), 128'(1));
      chk("nohaz_cnt", 128'(bubble_cnt), 128'(1));

      // Flush against a live entry with a new instruction offered
      send(0, 32'h400);
      present(1, 32'h404);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_if_ready", 128'(if_ready), 128'(0));
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_valid", 128'(id_valid), 128'(0));
      chk("flush_cnt", 128'(bubble_cnt), 128'(1));
      chk("flush_state", 128'(dbg_state), 128'(0));
      send(1, 32'h404);

      // Flush coinciding with a hazard: no bubble counted
      send(9, 32'h500);
      present(10, 32'h504);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_haz_valid", 128'(id_valid), 128'(0));
      chk("flush_haz_cnt", 128'(bubble_cnt), 128'(1));
      send(10, 32'h504);
      chk("flush_haz_wait", 128'(last_wait), 128'(1));

      // Five more hazards: the 2-bit counter saturates at 3
      for (int k = 0; k < 5; k++) begin
         send(9, 32'h600 + 32'(k * 8));
         send(10, 32'h604 + 32'(k * 8));
         chk("sat_main_cnt", 128'(bubble_cnt), 128'(2 + k));
         chk("sat_small_cnt", 128'(s_bubble_cnt), 128'((2 + k > 3) ? 3 : 2 + k));
      end

      // Table stream, back to back where no hazard intervenes
      for (int i = 0; i < 17; i++) send(ord[i], 32'h1000 + 32'(i * 4));
      chk("stream_cnt", 128'(bubble_cnt), 128'(8));
      chk("stream_sat_cnt", 128'(s_bubble_cnt), 128'(3));

      // Reset while stalled with a live entry
      send(3, 32'h2000);
      ex_ready = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_if_ready", 128'(if_ready), 128'(0));
      @(posedge clk);
      #1;
      chk("rst_fields", 128'(pack_act()), 128'(0));
      chk("rst_valid", 128'(id_valid), 128'(0));
      chk("rst_cnt", 128'(bubble_cnt), 128'(0));
      chk("rst_sat_cnt", 128'(s_bubble_cnt), 128'(0));
      chk("rst_state", 128'(dbg_state), 128'(0));
      rst_n    = 1'b1;
      ex_ready = 1'b1;
      send(0, 32'h3000);
      chk("post_rst_wait", 128'(last_wait), 128'(1));

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 128'(exp_q.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
